// File: rtl/toggle_line_decoder.sv
// rtl/toggle_line_decoder.sv - toggle-encoded serial line receiver with valid/ready word output; optional parity via TOGGLE_PARITY_CHECK_EN
module toggle_line_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             line_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic             parity_err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef TOGGLE_PARITY_CHECK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1} state_t;
`endif

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   shreg_q;
  logic               prev_line_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_valid_q;
  logic               overflow_q;
  logic               parity_err_q;

  logic               d_bit;
  logic               done_d;
  logic [WIDTH-1:0]   word_d;
  logic               perr_d;
  logic               accept_d;

  // Recover the bit from the line toggle and detect the strobe that finishes a frame.
  always_comb begin
    d_bit  = line_in ^ prev_line_q;
    done_d = 1'b0;
    word_d = shreg_q;
    perr_d = 1'b0;
    if (bit_en) begin
      case (state_q)
        S_DATA: begin
          word_d[WIDTH-1] = d_bit;
`ifndef TOGGLE_PARITY_CHECK_EN
          if (cnt_q == LAST_BIT) begin
            done_d = 1'b1;
          end
`endif
        end
`ifdef TOGGLE_PARITY_CHECK_EN
        S_PAR: begin
          // Even parity: data plus parity bit must XOR to zero.
          done_d = 1'b1;
          perr_d = ^{shreg_q, d_bit};
        end
`endif
        default: ;
      endcase
    end
  end

  // A completed word is taken only if the output slot is empty or being drained this cycle.
  assign accept_d = !out_valid_q || out_ready;

  // Frame state machine: start toggle, WIDTH data bits LSB first, optional parity bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      prev_line_q <= 1'b0;
    end else if (bit_en) begin
      prev_line_q <= line_in;
      case (state_q)
        S_IDLE: begin
          if (d_bit) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
          end
        end
        S_DATA: begin
          shreg_q[cnt_q] <= d_bit;
          if (cnt_q == LAST_BIT) begin
            cnt_q   <= '0;
`ifdef TOGGLE_PARITY_CHECK_EN
            state_q <= S_PAR;
`else
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output slot: load on completion when free, drop with a one-cycle overflow pulse otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (done_d) begin
        if (accept_d) begin
          out_data_q   <= word_d;
          out_valid_q  <= 1'b1;
          parity_err_q <= perr_d;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
